// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_pkg
// Purpose  : Shared definitions for the instruction fetch unit:
//            - instruction/address widths
//            - IR field bit positions
//            - FSM state encoding
//            - a helper that splits an instruction word into its fields
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

  localparam int c_INSTR_W = 16;
  localparam int c_ADDR_W  = 16;

  // IR field positions; rs and imm8 deliberately overlap
  localparam int c_OP_MSB  = 15;
  localparam int c_OP_LSB  = 12;
  localparam int c_RD_MSB  = 11;
  localparam int c_RD_LSB  = 8;
  localparam int c_RS_MSB  = 7;
  localparam int c_RS_LSB  = 4;
  localparam int c_IMM_MSB = 7;
  localparam int c_IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_FETCH   = 2'b01,
    S_DECODE  = 2'b10,
    S_EXECUTE = 2'b11
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [7:0] imm8;
  } fields_t;

  function automatic fields_t decode_fields(input logic [c_INSTR_W-1:0] instr);
    fields_t f;
    f.op   = instr[c_OP_MSB:c_OP_LSB];
    f.rd   = instr[c_RD_MSB:c_RD_LSB];
    f.rs   = instr[c_RS_MSB:c_RS_LSB];
    f.imm8 = instr[c_IMM_MSB:c_IMM_LSB];
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Purpose  : Bus bundle between the fetch unit, instruction memory and the
//            control unit.
// Signals  : mem_req/mem_addr (out), mem_ack/mem_rdata (in)   - memory port
//            exec_done/branch_taken/branch_target (in)         - from control
//            op/rd/rs/imm8/ir_valid (out)                      - decoded IR
// Modports : master = fetch unit side, slave = memory/control side
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic                  mem_req;
  logic [c_ADDR_W-1:0]   mem_addr;
  logic                  mem_ack;
  logic [c_INSTR_W-1:0]  mem_rdata;
  logic                  exec_done;
  logic                  branch_taken;
  logic [c_ADDR_W-1:0]   branch_target;
  logic [3:0]            op;
  logic [3:0]            rd;
  logic [3:0]            rs;
  logic [7:0]            imm8;
  logic                  ir_valid;

  modport master (
    output mem_req, mem_addr, op, rd, rs, imm8, ir_valid,
    input  mem_ack, mem_rdata, exec_done, branch_taken, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, op, rd, rs, imm8, ir_valid,
    output mem_ack, mem_rdata, exec_done, branch_taken, branch_target
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_pc_register.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_pc_register
// Purpose  : Program counter register. load has priority over inc; the
//            increment wraps at 16 bits.
// Ports    : clk, reset (async, active-high), inc, load, load_val[15:0],
//            pc[15:0] (out)
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit_pc_register
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [c_ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                load,
  input  logic [c_ADDR_W-1:0] load_val,
  output logic [c_ADDR_W-1:0] pc
);

  logic [c_ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (load) begin
      r_pc <= load_val;
    end else if (inc) begin
      r_pc <= r_pc + {{(c_ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Owns the PC, fetches 16-bit instructions over a req/ack port,
//            latches IR and presents decoded fields for one DECODE cycle,
//            then waits in EXECUTE for exec_done (optionally branching).
// Ports    : clk, reset (async, active-high), en,
//            bus (instr_fetch_unit_if.master), pc[15:0], state[1:0],
//            fetch_err
// Config   : FETCH_TIMEOUT_EN - when defined, a FETCH that sees no ack for
//            TIMEOUT_CYCLES cycles aborts to IDLE and sets a sticky
//            fetch_err. When undefined, FETCH waits forever and fetch_err=0.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [c_ADDR_W-1:0] RESET_PC       = 16'h0000,
  parameter int                  TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  instr_fetch_unit_if.master    bus,
  output logic [c_ADDR_W-1:0]   pc,
  output logic [1:0]            state,
  output logic                  fetch_err
);

  state_t               r_state;
  state_t               w_next_state;
  logic [c_INSTR_W-1:0] r_ir;
  logic                 r_mem_req;
  logic [c_ADDR_W-1:0]  w_pc;
  logic                 w_ack;
  logic                 w_pc_load;
  logic                 w_timeout;
  logic                 w_err;
  fields_t              w_fields;

  // An ack is only meaningful while we are actually fetching
  assign w_ack     = (r_state == S_FETCH) && bus.mem_ack;
  assign w_pc_load = (r_state == S_EXECUTE) && bus.exec_done && bus.branch_taken;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_to_cnt;
  logic        r_fetch_err;

  // Counter sits at zero outside FETCH, so it starts from zero on entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt    <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (r_state != S_FETCH) begin
        r_to_cnt <= '0;
      end else if (!bus.mem_ack) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign w_timeout = (r_state == S_FETCH) && !bus.mem_ack && (r_to_cnt == c_TO_LAST);
  assign w_err     = r_fetch_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout    = 1'b0;
  assign w_err        = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (en && !w_err) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_ack) begin
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      S_DECODE: begin
        w_next_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (bus.exec_done) begin
          w_next_state = en ? S_FETCH : S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // mem_req is registered from the next state so it is high for every
  // FETCH cycle and drops the cycle after the accepting ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir      <= '0;
      r_mem_req <= 1'b0;
    end else begin
      r_mem_req <= (w_next_state == S_FETCH);
      if (w_ack) begin
        r_ir <= bus.mem_rdata;
      end
    end
  end

  instr_fetch_unit_pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_ack),
    .load     (w_pc_load),
    .load_val (bus.branch_target),
    .pc       (w_pc)
  );

  // ------------------------------------------------------------ outputs
  assign w_fields     = decode_fields(r_ir);
  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = w_pc;
  assign bus.op       = w_fields.op;
  assign bus.rd       = w_fields.rd;
  assign bus.rs       = w_fields.rs;
  assign bus.imm8     = w_fields.imm8;
  assign bus.ir_valid = (r_state == S_DECODE);
  assign pc           = w_pc;
  assign state        = r_state;
  assign fetch_err    = w_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit. The bench plays both
//            instruction memory (random contents, random wait states) and
//            control unit (random execute length, random branches), and
//            tracks the expected PC instruction by instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam logic [15:0] c_RESET_PC = 16'h0000;
  localparam logic [1:0]  c_IDLE     = 2'b00;
  localparam logic [1:0]  c_FETCH    = 2'b01;
  localparam logic [1:0]  c_DECODE   = 2'b10;
  localparam logic [1:0]  c_EXECUTE  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] pc;
  logic [1:0]  state;
  logic        fetch_err;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC       (c_RESET_PC),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .bus       (bus),
    .pc        (pc),
    .state     (state),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: PC and sparse memory image
  logic [15:0] m_pc;
  logic [15:0] mem [logic [15:0]];

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  task automatic drive_quiet();
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = 16'h0000;
    bus.exec_done     = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0000;
  endtask

  // inputs that must be ignored in the current state
  task automatic drive_noise();
    bus.exec_done     = 1'($urandom);
    bus.branch_taken  = 1'($urandom);
    bus.branch_target = 16'($urandom);
    en                = 1'($urandom);
  endtask

  task automatic check_reset_values(input string tag);
    n_vec++;
    if ({state, pc, bus.mem_req, bus.mem_addr, bus.ir_valid, fetch_err} !==
        {c_IDLE, c_RESET_PC, 1'b0, c_RESET_PC, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s ctrl: state=%h pc=%h req=%b addr=%h irv=%b err=%b, want state=0 pc=%h req=0 addr=%h irv=0 err=0",
               tag, state, pc, bus.mem_req, bus.mem_addr, bus.ir_valid, fetch_err, c_RESET_PC, c_RESET_PC);
    end
    n_vec++;
    if ({bus.op, bus.rd, bus.rs, bus.imm8} !== 20'h0) begin
      n_err++;
      $display("FAIL %s fields: op=%h rd=%h rs=%h imm8=%h, want all 0", tag, bus.op, bus.rd, bus.rs, bus.imm8);
    end
  endtask

  // One instruction, entered at a negedge while in FETCH.
  task automatic run_instr(input int waits, input int exdly, input bit br,
                           input logic [15:0] tgt, input bit en_after);
    logic [15:0] w;
    w = word_at(m_pc);
    n_vec++;
    if (state !== c_FETCH || bus.mem_req !== 1'b1 || bus.mem_addr !== m_pc) begin
      n_err++;
      $display("FAIL fetch_entry: state=%h req=%b addr=%h, want state=1 req=1 addr=%h", state, bus.mem_req, bus.mem_addr, m_pc);
    end
    for (int i = 0; i < waits; i++) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'($urandom);
      drive_noise();
      @(negedge clk);
      n_vec++;
      if (state !== c_FETCH || bus.mem_req !== 1'b1 || bus.mem_addr !== m_pc || pc !== m_pc) begin
        n_err++;
        $display("FAIL fetch_wait%0d: state=%h req=%b addr=%h pc=%h, want state=1 req=1 addr=pc=%h", i, state, bus.mem_req, bus.mem_addr, pc, m_pc);
      end
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = w;
    drive_noise();
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'($urandom);
    drive_noise();
    m_pc = m_pc + 16'd1;
    n_vec++;
    if (state !== c_DECODE || bus.ir_valid !== 1'b1 || bus.mem_req !== 1'b0 || pc !== m_pc) begin
      n_err++;
      $display("FAIL decode_ctrl: state=%h irv=%b req=%b pc=%h, want state=2 irv=1 req=0 pc=%h", state, bus.ir_valid, bus.mem_req, pc, m_pc);
    end
    n_vec++;
    if (bus.op !== w[15:12] || bus.rd !== w[11:8] || bus.rs !== w[7:4] || bus.imm8 !== w[7:0]) begin
      n_err++;
      $display("FAIL decode_fields: op=%h rd=%h rs=%h imm8=%h, want word %h", bus.op, bus.rd, bus.rs, bus.imm8, w);
    end
    @(negedge clk);
    n_vec++;
    if (state !== c_EXECUTE || bus.ir_valid !== 1'b0 || pc !== m_pc ||
        {bus.op, bus.rd, bus.imm8} !== {w[15:8], w[7:0]}) begin
      n_err++;
      $display("FAIL execute_entry: state=%h irv=%b pc=%h ir=%h%h%h, want state=3 irv=0 pc=%h ir=%h", state, bus.ir_valid, pc, bus.op, bus.rd, bus.imm8, m_pc, w);
    end
    for (int i = 1; i < exdly; i++) begin
      bus.exec_done     = 1'b0;
      bus.branch_taken  = 1'($urandom);
      bus.branch_target = 16'($urandom);
      en                = 1'($urandom);
      @(negedge clk);
      n_vec++;
      if (state !== c_EXECUTE || pc !== m_pc) begin
        n_err++;
        $display("FAIL execute_wait%0d: state=%h pc=%h, want state=3 pc=%h", i, state, pc, m_pc);
      end
    end
    bus.exec_done     = 1'b1;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    en                = en_after;
    @(negedge clk);
    drive_quiet();
    if (br) m_pc = tgt;
    n_vec++;
    if (state !== (en_after ? c_FETCH : c_IDLE) || pc !== m_pc || bus.mem_req !== en_after) begin
      n_err++;
      $display("FAIL exec_done: state=%h pc=%h req=%b, want state=%h pc=%h req=%b", state, pc, bus.mem_req, en_after ? c_FETCH : c_IDLE, m_pc, en_after);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b0;
    drive_quiet();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    m_pc  = c_RESET_PC;
    @(negedge clk);
    n_vec++;
    if (state !== c_IDLE || bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold: state=%h req=%b, want state=0 req=0", state, bus.mem_req);
    end
  endtask

  task automatic start_run();
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    mem[16'h0000] = 16'h1234;
    start_run();
    run_instr(0, 1, 1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_wait_states();
    run_instr(5, 2, 1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_branch();
    run_instr(0, 1, 1'b1, 16'h0040, 1'b1);
    run_instr(0, 1, 1'b0, 16'h0000, 1'b1);
    n_vec++;
    if (pc !== 16'h0041) begin
      n_err++;
      $display("FAIL branch_then_inc: pc=%h, want 0041", pc);
    end
  endtask

  task automatic test_wrap();
    run_instr(0, 1, 1'b1, 16'hFFFF, 1'b1);
    run_instr(1, 1, 1'b0, 16'h0000, 1'b1);
    n_vec++;
    if (pc !== 16'h0000) begin
      n_err++;
      $display("FAIL pc_wrap: pc=%h, want 0000", pc);
    end
  endtask

  task automatic test_random();
    repeat (40) begin
      run_instr(int'($urandom_range(0, 4)), int'($urandom_range(1, 4)),
                ($urandom_range(0, 2) == 0), 16'($urandom), 1'b1);
    end
  endtask

  task automatic test_en_drop();
    run_instr(1, 2, 1'b0, 16'h0000, 1'b0);
    repeat (4) begin
      bus.mem_ack   = 1'b1;
      bus.exec_done = 1'b1;
      @(negedge clk);
      n_vec++;
      if (state !== c_IDLE || bus.mem_req !== 1'b0 || pc !== m_pc) begin
        n_err++;
        $display("FAIL en_low_idle: state=%h req=%b pc=%h, want state=0 req=0 pc=%h", state, bus.mem_req, pc, m_pc);
      end
    end
    drive_quiet();
    start_run();
    run_instr(0, 1, 1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_reset_mid_fetch();
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values("reset_async");
    en            = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    @(negedge clk);
    reset = 1'b0;
    m_pc  = c_RESET_PC;
    repeat (3) begin
      @(negedge clk);
      check_reset_values("late_ack");
    end
    drive_quiet();
  endtask

  task automatic test_timeout();
    start_run();
`ifdef FETCH_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      n_vec++;
      if (state !== c_FETCH || fetch_err !== 1'b0 || bus.mem_req !== 1'b1) begin
        n_err++;
        $display("FAIL timeout_pending%0d: state=%h err=%b req=%b, want state=1 err=0 req=1", k, state, fetch_err, bus.mem_req);
      end
      @(negedge clk);
    end
    repeat (5) begin
      en = 1'b1;
      n_vec++;
      if (state !== c_IDLE || fetch_err !== 1'b1 || bus.mem_req !== 1'b0 || pc !== m_pc) begin
        n_err++;
        $display("FAIL timeout_err: state=%h err=%b req=%b pc=%h, want state=0 err=1 req=0 pc=%h", state, fetch_err, bus.mem_req, pc, m_pc);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    n_vec++;
    if (fetch_err !== 1'b0 || state !== c_IDLE) begin
      n_err++;
      $display("FAIL timeout_clear: err=%b state=%h, want err=0 state=0", fetch_err, state);
    end
`else
    for (int k = 0; k < 40; k++) begin
      n_vec++;
      if (state !== c_FETCH || fetch_err !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== m_pc) begin
        n_err++;
        $display("FAIL no_timeout%0d: state=%h err=%b req=%b addr=%h, want state=1 err=0 req=1 addr=%h", k, state, fetch_err, bus.mem_req, bus.mem_addr, m_pc);
      end
      @(negedge clk);
    end
    run_instr(0, 1, 1'b0, 16'h0000, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_branch();
    test_wrap();
    test_random();
    test_en_drop();
    test_reset_mid_fetch();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
